// File: rtl/sdram_pkg.sv
// Shared SDRAM-side definitions: controller widths, write-queue entry layout and queue FSM states.
// Used by the controller, the line-buffer logic and the write queue.
package sdram_pkg;

  localparam int unsigned SDRAM_AW = 22;
  localparam int unsigned SDRAM_DW = 16;

  typedef struct packed {
    logic [SDRAM_AW-1:0] addr;
    logic [SDRAM_DW-1:0] data;
  } wr_entry_t;

  typedef enum logic [0:0] {
    S_IDLE,
    S_OFFER
  } wrq_state_e;

endpackage

// File: rtl/wrq_store.sv
// Write-queue register file: one synchronous write port, asynchronous head read and,
// with SDRAM_WRQ_MERGE_EN, a second asynchronous read of the newest entry.
module wrq_store #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned WIDTH = 38,
  localparam int unsigned IW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [IW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
`ifdef SDRAM_WRQ_MERGE_EN
  ,
  input  logic [IW-1:0]    taddr,
  output logic [WIDTH-1:0] tdata
`endif
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents carry no reset; validity is tracked by the pointers in the top.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

`ifdef SDRAM_WRQ_MERGE_EN
  assign tdata = mem_q[taddr];
`endif

endmodule

// File: rtl/sdram_wrqueue.sv
// Host write queue in front of the SDRAM controller write port; drains only while lock=0.
// Define SDRAM_WRQ_MERGE_EN to fold a write to the newest entry's address into that entry.
module sdram_wrqueue
  import sdram_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned AW    = SDRAM_AW,
  parameter  int unsigned DW    = SDRAM_DW,
  localparam int unsigned PW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  input  logic          lock,
  output logic          sd_valid,
  output logic [AW-1:0] sd_addr,
  output logic [DW-1:0] sd_data,
  input  logic          sd_ack,
  output logic [PW-1:0] level,
  output logic          overflow,
  input  logic          clr_ovf
);

  localparam int unsigned IW = PW - 1;
  localparam int unsigned EW = AW + DW;

  wrq_state_e    state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] sd_addr_q;
  logic [DW-1:0] sd_data_q;

  logic          empty, push, merge, load, store_we;
  logic [IW-1:0] store_waddr;
  logic [EW-1:0] head_entry, load_entry;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign level    = wr_ptr_q - rd_ptr_q;
  assign wr_ready = ~full_q;
  assign sd_valid = (state_q == S_OFFER);
  assign sd_addr  = sd_addr_q;
  assign sd_data  = sd_data_q;
  assign overflow = ovf_q;

`ifdef SDRAM_WRQ_MERGE_EN
  logic [PW-1:0] tail_ptr;
  logic [IW-1:0] tail_idx;
  logic [EW-1:0] tail_entry;

  assign tail_ptr = wr_ptr_q - PW'(1);
  assign tail_idx = tail_ptr[IW-1:0];
  // The newest entry may be rewritten unless it is the head already latched for the controller.
  assign merge    = wr_req && !empty && (tail_entry[EW-1:DW] == wr_addr) &&
                    ((level > PW'(1)) || (state_q == S_IDLE));
  assign store_waddr = merge ? tail_idx : wr_ptr_q[IW-1:0];
  // Same-edge merge into the entry being loaded must reach the output registers too.
  assign load_entry  = (merge && (tail_idx == rd_ptr_d[IW-1:0])) ? {wr_addr, wr_data}
                                                                   : head_entry;
`else
  assign merge       = 1'b0;
  assign store_waddr = wr_ptr_q[IW-1:0];
  assign load_entry  = head_entry;
`endif

  assign push     = wr_req && !full_q && !merge;
  assign store_we = push || merge;

  wrq_store #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_store (
    .clock (clock),
    .we    (store_we),
    .waddr (store_waddr),
    .wdata ({wr_addr, wr_data}),
    .raddr (rd_ptr_d[IW-1:0]),
    .rdata (head_entry)
`ifdef SDRAM_WRQ_MERGE_EN
    ,
    .taddr (tail_idx),
    .tdata (tail_entry)
`endif
  );

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    load     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty && !lock) begin
          load    = 1'b1;
          state_d = S_OFFER;
        end
      end
      S_OFFER: begin
        if (sd_ack) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          // Ack wins over lock; lock only decides whether the next entry follows.
          if ((wr_ptr_q != rd_ptr_d) && !lock) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else if (lock) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    full_d   = (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) && (wr_ptr_d[IW-1:0] == rd_ptr_d[IW-1:0]);
    ovf_d    = ovf_q;
    if (wr_req && full_q && !merge) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      sd_addr_q <= '0;
      sd_data_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      if (load) begin
        sd_addr_q <= load_entry[EW-1:DW];
        sd_data_q <= load_entry[DW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_sdram_wrqueue.sv
// Directed self-checking bench for sdram_wrqueue: drain, full/overflow, withdraw, ack+lock,
// reset mid-drain and same-address merge (expectations follow SDRAM_WRQ_MERGE_EN).
module tb_sdram_wrqueue;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 22;
  localparam int unsigned DW    = 16;
  localparam int unsigned PW    = 5;

  logic          clock;
  logic          reset_n;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          lock;
  logic          sd_valid;
  logic [AW-1:0] sd_addr;
  logic [DW-1:0] sd_data;
  logic          sd_ack;
  logic [PW-1:0] level;
  logic          overflow;
  logic          clr_ovf;

  int checks   = 0;
  int failures = 0;

  sdram_wrqueue #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .lock     (lock),
    .sd_valid (sd_valid),
    .sd_addr  (sd_addr),
    .sd_data  (sd_data),
    .sd_ack   (sd_ack),
    .level    (level),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    wr_req  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    lock    = 1'b0;
    sd_ack  = 1'b0;
    clr_ovf = 1'b0;
    tick();
    tick();
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_sd_valid", 32'(sd_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_sd_addr", 32'(sd_addr), 32'd0);
    check("rst_sd_data", 32'(sd_data), 32'd0);
    reset_n = 1'b1;
    tick();

    // Three writes, ack tied high: valid two cycles after the first push, then 3 beats.
    sd_ack  = 1'b1;
    wr_req  = 1'b1;
    wr_addr = 22'h000100;
    wr_data = 16'hF800;
    tick();
    check("t1_level1", 32'(level), 32'd1);
    check("t1_novalid", 32'(sd_valid), 32'd0);
    wr_addr = 22'h000101;
    wr_data = 16'h07E0;
    tick();
    check("t1_valid_lat2", 32'(sd_valid), 32'd1);
    check("t1_beat0_addr", 32'(sd_addr), 32'h100);
    check("t1_beat0_data", 32'(sd_data), 32'hF800);
    wr_addr = 22'h000102;
    wr_data = 16'h001F;
    tick();
    wr_req = 1'b0;
    check("t1_beat1_valid", 32'(sd_valid), 32'd1);
    check("t1_beat1_addr", 32'(sd_addr), 32'h101);
    check("t1_beat1_data", 32'(sd_data), 32'h07E0);
    check("t1_level_mid", 32'(level), 32'd2);
    tick();
    check("t1_beat2_valid", 32'(sd_valid), 32'd1);
    check("t1_beat2_addr", 32'(sd_addr), 32'h102);
    check("t1_beat2_data", 32'(sd_data), 32'h001F);
    tick();
    check("t1_end_valid", 32'(sd_valid), 32'd0);
    check("t1_end_level", 32'(level), 32'd0);

    // Fill under lock, one refused push sets overflow, clear it, then drain in order.
    sd_ack = 1'b0;
    lock   = 1'b1;
    wr_req = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_addr = 22'h000300 + 22'(i);
      wr_data = 16'hA000 + 16'(i);
      tick();
      if (i == 15) begin
        check("t2_full_ready", 32'(wr_ready), 32'd0);
        check("t2_full_level", 32'(level), 32'd16);
        check("t2_no_ovf_yet", 32'(overflow), 32'd0);
      end
    end
    wr_req = 1'b0;
    check("t2_overflow", 32'(overflow), 32'd1);
    check("t2_level_after_refuse", 32'(level), 32'd16);
    check("t2_locked_novalid", 32'(sd_valid), 32'd0);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("t2_ovf_cleared", 32'(overflow), 32'd0);
    lock   = 1'b0;
    sd_ack = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t2_drain%0d_valid", i), 32'(sd_valid), 32'd1);
      check($sformatf("t2_drain%0d_addr", i), 32'(sd_addr), 32'h300 + 32'(i));
      check($sformatf("t2_drain%0d_data", i), 32'(sd_data), 32'hA000 + 32'(i));
      tick();
    end
    check("t2_end_valid", 32'(sd_valid), 32'd0);
    check("t2_end_level", 32'(level), 32'd0);
    check("t2_end_ready", 32'(wr_ready), 32'd1);

    // Withdraw on lock, then re-offer the same entry.
    sd_ack  = 1'b0;
    wr_req  = 1'b1;
    wr_addr = 22'h000400;
    wr_data = 16'h1234;
    tick();
    wr_addr = 22'h000401;
    wr_data = 16'h5678;
    tick();
    wr_req = 1'b0;
    check("t3_offer_a", 32'(sd_valid), 32'd1);
    check("t3_offer_a_addr", 32'(sd_addr), 32'h400);
    tick();
    lock = 1'b1;
    tick();
    check("t3_withdrawn", 32'(sd_valid), 32'd0);
    check("t3_level_kept", 32'(level), 32'd2);
    tick();
    check("t3_stay_idle", 32'(sd_valid), 32'd0);
    lock = 1'b0;
    tick();
    check("t3_reoffer_valid", 32'(sd_valid), 32'd1);
    check("t3_reoffer_addr", 32'(sd_addr), 32'h400);
    check("t3_reoffer_data", 32'(sd_data), 32'h1234);

    // Ack and lock together: head popped, no follow-on offer.
    sd_ack = 1'b1;
    lock   = 1'b1;
    tick();
    check("t4_ack_lock_valid", 32'(sd_valid), 32'd0);
    check("t4_ack_lock_level", 32'(level), 32'd1);
    lock = 1'b0;
    tick();
    check("t4_next_valid", 32'(sd_valid), 32'd1);
    check("t4_next_addr", 32'(sd_addr), 32'h401);
    check("t4_next_data", 32'(sd_data), 32'h5678);
    tick();
    check("t4_end_level", 32'(level), 32'd0);
    check("t4_end_valid", 32'(sd_valid), 32'd0);

    // Asynchronous reset in the middle of a drain.
    sd_ack = 1'b0;
    lock   = 1'b1;
    wr_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_addr = 22'h000500 + 22'(i);
      wr_data = 16'hB000 + 16'(i);
      tick();
    end
    wr_req = 1'b0;
    check("t5_level6", 32'(level), 32'd6);
    lock   = 1'b0;
    sd_ack = 1'b1;
    tick();
    tick();
    check("t5_level5", 32'(level), 32'd5);
    check("t5_mid_addr", 32'(sd_addr), 32'h501);
    reset_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(sd_valid), 32'd0);
    check("t5_rst_level", 32'(level), 32'd0);
    check("t5_rst_ready", 32'(wr_ready), 32'd1);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    check("t5_post_valid", 32'(sd_valid), 32'd0);
    check("t5_post_level", 32'(level), 32'd0);

    // Two writes to one address under lock.
    sd_ack  = 1'b0;
    lock    = 1'b1;
    wr_req  = 1'b1;
    wr_addr = 22'h000200;
    wr_data = 16'h1111;
    tick();
    wr_data = 16'h2222;
    tick();
    wr_req = 1'b0;
`ifdef SDRAM_WRQ_MERGE_EN
    check("t6_merged_level", 32'(level), 32'd1);
`else
    check("t6_level", 32'(level), 32'd2);
`endif
    check("t6_no_ovf", 32'(overflow), 32'd0);
    lock   = 1'b0;
    sd_ack = 1'b1;
    tick();
    check("t6_beat0_valid", 32'(sd_valid), 32'd1);
    check("t6_beat0_addr", 32'(sd_addr), 32'h200);
`ifdef SDRAM_WRQ_MERGE_EN
    check("t6_beat0_data", 32'(sd_data), 32'h2222);
    tick();
    check("t6_single_beat", 32'(sd_valid), 32'd0);
`else
    check("t6_beat0_data", 32'(sd_data), 32'h1111);
    tick();
    check("t6_beat1_valid", 32'(sd_valid), 32'd1);
    check("t6_beat1_data", 32'(sd_data), 32'h2222);
    tick();
    check("t6_end_valid", 32'(sd_valid), 32'd0);
`endif
    check("t6_end_level", 32'(level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_wrqueue.md
Name: sdram_wrqueue

Overview:
- Write-side queue that sits directly upstream of the SDRAM/VGA controller's host write port (address, data, lock).
- Host/CPU logic pushes word writes at any time. The queue buffers them in a FIFO.
- Entries drain to the controller only while lock=0, i.e. outside line-refill bursts and init, through a valid/ack handshake.
- Host never stalls on lock; it stalls only on a full queue.

Parameters:
- DEPTH, 16: FIFO entries, power of two, 4..64.
- AW, 22: word address width; matches the controller's address port.
- DW, 16: data width (RGB565 pixel word).

Ports:
- clock  in  1  100 MHz system clock, same as the SDRAM controller.
- reset_n  in  1  asynchronous active-low reset.
- wr_req  in  1  host write strobe; one write per cycle.
- wr_addr  in  AW  host word address.
- wr_data  in  DW  host write data.
- wr_ready  out  1  queue can accept; equals !full (registered).
- lock  in  1  from controller; 1 = no writes may be issued.
- sd_valid  out  1  write request to controller.
- sd_addr  out  AW  request address (registered).
- sd_data  out  DW  request data (registered).
- sd_ack  in  1  controller accepted the current request this cycle.
- level  out  log2(DEPTH)+1  number of stored entries, including the one being offered.
- overflow  out  1  sticky; set when wr_req arrives while wr_ready=0.
- clr_ovf  in  1  synchronous clear of overflow.

Behaviour:
- Clock and reset:
  - One clock domain.
  - Interface: one clock; reset is asynchronous and active-low (clock, reset_n).
- Reset values: wr_ready=1, sd_valid=0, sd_addr=0, sd_data=0, level=0, overflow=0, FSM=S_IDLE, rd_ptr=0, wr_ptr=0.
- Reset mid-operation: any pending request is discarded without ack, and all queue contents are lost.
- Push:
  - Occurs when wr_req && wr_ready.
  - The entry is written at wr_ptr; wr_ptr and level update on the next edge.
  - wr_ready uses the registered full flag. When full, a push is refused even if a pop happens in the same cycle.
  - A refused wr_req sets overflow. If clr_ovf and a refused wr_req occur in the same cycle, set wins.
- Pointers: log2(DEPTH)+1 bits with a wrap bit. full = MSBs differ and LSBs equal; empty = pointers equal. Wrap-around is natural binary.
- FSM S_IDLE:
  - If !empty && !lock: load head into sd_addr/sd_data and go to S_OFFER.
  - sd_valid=1 from the next cycle.
  - Latency from first push into an empty queue with lock=0 to sd_valid=1 is 2 cycles.
- FSM S_OFFER:
  - sd_valid=1; sd_addr and sd_data are held stable.
  - On sd_ack: pop (rd_ptr+1, level-1).
    - If another entry exists and lock=0, load it the same edge and stay in S_OFFER. This gives back-to-back transfers at 1 word/cycle.
    - Otherwise deassert sd_valid and go to S_IDLE.
  - If lock rises while not acked: withdraw. sd_valid=0 next cycle, no pop, go to S_IDLE, and re-offer the same entry after lock falls.
  - sd_ack and lock in the same cycle: the ack wins. The entry is popped, then the withdraw rule applies for the next entry.
- Simultaneous push and pop: level is unchanged.
- Push into an empty queue while S_IDLE: the entry is not visible to the FSM until the following cycle.
- sd_ack with sd_valid=0 is ignored.
- Ordering is strictly FIFO. No reordering across addresses.

Optional Feature:
- Macro: SDRAM_WRQ_MERGE_EN.
- Defined:
  - A push whose wr_addr equals the address of the newest stored entry overwrites that entry's data in place. level and wr_ptr are unchanged, and wr_ready is not required.
  - This applies only if that entry is not the head currently loaded in S_OFFER (level>=2, or level==1 and FSM in S_IDLE).
  - A merged write never sets overflow.
- Undefined:
  - Every accepted push allocates a new entry; no address comparator is built.

Decomposition:
- Package sdram_pkg:
  - SDRAM_AW=22, SDRAM_DW=16.
  - Write-entry struct {addr, data}.
  - FSM enum {S_IDLE, S_OFFER}.
  - Shared with the controller and the line-buffer logic.
- Sub-module wrq_store:
  - DEPTH x (AW+DW) register file.
  - One synchronous write port; asynchronous read at rd_ptr and at wr_ptr-1 (the second read port is needed for merge).
  - The top holds the pointers, flags and FSM.

Test Plan:
- Reset, then push 3 writes (0x000100/0xF800, 0x000101/0x07E0, 0x000102/0x001F) with lock=0, sd_ack tied 1 -> sd_valid rises 2 cycles after the first push; 3 consecutive acked beats in order; level returns to 0.
- lock=1, push DEPTH+1 writes -> wr_ready=0 after 16 pushes, level=16, overflow=1, no sd_valid. clr_ovf -> overflow=0. Drop lock -> 16 entries drain in order; the 17th is absent.
- sd_valid=1 on entry A, raise lock before ack -> sd_valid=0 next cycle, level unchanged. Lower lock -> entry A re-offered with identical addr/data.
- sd_ack and lock asserted in the same cycle with 2 entries queued -> first entry popped, sd_valid=0 next cycle, level=1.
- Assert reset_n=0 mid-drain with level=5 -> immediately sd_valid=0, level=0, wr_ready=1; no further acks consumed.
- With SDRAM_WRQ_MERGE_EN defined and lock=1: push 0x000200/0x1111 then 0x000200/0x2222 -> level=1. Drop lock -> a single beat with data 0x2222. Without the macro -> level=2 and two beats.
